// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking convolution datapath: data/packet
// widths, result-packet field positions, the packet builder used by the
// partial-sum accumulator (and decoded by the result memory), and the
// accumulator state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int WIDTH_DATA = 13;
  localparam int WIDTH_PKT  = 32;
  localparam int WIDTH_ADDR = 9;
  localparam int THRE       = 64;

  // Result packet layout: [12:0] potential, [21:13] address, rest zero.
  localparam int DATA_LSB   = 0;
  localparam int ADDR_LSB   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  // Build a result packet; unused upper bits are forced to zero.
  function automatic logic [WIDTH_PKT-1:0] pack_result(
    input logic [WIDTH_ADDR-1:0] addr,
    input logic [WIDTH_DATA-1:0] data
  );
    logic [WIDTH_PKT-1:0] pkt;
    pkt = {WIDTH_PKT{1'b0}};
    pkt[DATA_LSB +: WIDTH_DATA] = data;
    pkt[ADDR_LSB +: WIDTH_ADDR] = addr;
    return pkt;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// ---------------------------------------------------------------------------
// psum_accumulator_if
// Handshake bundle of the partial-sum accumulator: the partial-sum input
// stream (valid/ready/data) and the result-packet output stream.
// Signals:
//   in_valid  : partial sum valid          (producer -> accumulator)
//   in_ready  : accumulator takes a psum   (accumulator -> producer)
//   in_psum   : partial sum, WIDTH_DATA    (producer -> accumulator)
//   out_valid : result packet valid        (accumulator -> result memory)
//   out_ready : result memory takes packet (result memory -> accumulator)
//   out_pkt   : result packet, WIDTH_PKT   (accumulator -> result memory)
// Modports: master = environment side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int WIDTH_DATA = 13,
  parameter int WIDTH_PKT  = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH_DATA-1:0] in_psum;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH_PKT-1:0]  out_pkt;

  modport master (
    output in_valid,
    output in_psum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_pkt
  );

  modport slave (
    input  in_valid,
    input  in_psum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_pkt
  );

endinterface

// File: rtl/psum_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational unsigned saturating adder. The sum is formed one bit wider
// than the operands; a carry out clamps the result to all-ones and raises
// o_ovf.
// Ports:
//   i_a, i_b : operands, WIDTH bits
//   o_sum    : saturated sum, WIDTH bits
//   o_ovf    : 1 when the sum was clamped
// ---------------------------------------------------------------------------
module sat_add #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[WIDTH];
  assign o_sum  = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
// Sums NUM_PSUM consecutive partial sums per output neuron into a saturating
// WIDTH_DATA-bit potential, walks the DEPTH_R x DEPTH_R output map in
// row-major order and emits one result packet per neuron to the result
// memory. A frame starts on a start pulse in IDLE and ends with a one-cycle
// frame_done after the last neuron's packet is accepted.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : one-cycle frame start pulse, honoured only in IDLE
//   bus        : slave side of psum_accumulator_if (psum in, packet out)
//   frame_done : one-cycle pulse after the last packet is accepted
//   sat_seen   : sticky flag, some neuron sum saturated in this frame
// ---------------------------------------------------------------------------
module psum_accumulator #(
  parameter int WIDTH_DATA = snn_pkg::WIDTH_DATA,
  parameter int WIDTH_PKT  = snn_pkg::WIDTH_PKT,
  parameter int WIDTH_ADDR = snn_pkg::WIDTH_ADDR,
  parameter int DEPTH_R    = 21,
  parameter int NUM_PSUM   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  psum_accumulator_if.slave   bus,
  output logic                frame_done,
  output logic                sat_seen
);

  import snn_pkg::*;

  localparam int NUM_NEUR  = DEPTH_R * DEPTH_R;
  // A single-psum configuration still needs a 1-bit counter.
  localparam int WIDTH_CNT = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1;
  localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = WIDTH_ADDR'(NUM_NEUR - 1);
  localparam logic [WIDTH_CNT-1:0]  LAST_CNT  = WIDTH_CNT'(NUM_PSUM - 1);

  acc_state_t            r_state;
  acc_state_t            w_state_nxt;
  logic [WIDTH_DATA-1:0] r_acc;
  logic [WIDTH_DATA-1:0] w_acc_nxt;
  logic [WIDTH_CNT-1:0]  r_cnt;
  logic [WIDTH_CNT-1:0]  w_cnt_nxt;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH_ADDR-1:0] w_addr_nxt;
  logic                  r_out_valid;
  logic                  w_out_valid_nxt;
  logic [WIDTH_PKT-1:0]  r_out_pkt;
  logic [WIDTH_PKT-1:0]  w_out_pkt_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;
  logic                  r_sat_seen;
  logic                  w_sat_seen_nxt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last_psum;
  logic                  w_last_addr;
  logic [WIDTH_DATA-1:0] w_sum;
  logic                  w_sum_ovf;

  // in_ready is the only output decoded straight from the state register.
  assign w_in_ready  = (r_state == ACCUM);
  assign w_accept    = w_in_ready & bus.in_valid;
  assign w_last_psum = (r_cnt == LAST_CNT);
  assign w_last_addr = (r_addr == LAST_ADDR);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pkt   = r_out_pkt;
  assign frame_done    = r_frame_done;
  assign sat_seen      = r_sat_seen;

  sat_add #(
    .WIDTH (WIDTH_DATA)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (bus.in_psum),
    .o_sum (w_sum),
    .o_ovf (w_sum_ovf)
  );

  // State and output/datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= {WIDTH_DATA{1'b0}};
      r_cnt        <= {WIDTH_CNT{1'b0}};
      r_addr       <= {WIDTH_ADDR{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_pkt    <= {WIDTH_PKT{1'b0}};
      r_frame_done <= 1'b0;
      r_sat_seen   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_pkt    <= w_out_pkt_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sat_seen   <= w_sat_seen_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_accept && w_last_psum) begin
          w_state_nxt = EMIT;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          w_state_nxt = w_last_addr ? DONE : ACCUM;
        end else begin
          w_state_nxt = EMIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_out_valid_nxt  = r_out_valid;
    w_out_pkt_nxt    = r_out_pkt;
    w_frame_done_nxt = 1'b0;
    w_sat_seen_nxt   = r_sat_seen;
    case (r_state)
      IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (start) begin
          w_addr_nxt     = {WIDTH_ADDR{1'b0}};
          w_acc_nxt      = {WIDTH_DATA{1'b0}};
          w_cnt_nxt      = {WIDTH_CNT{1'b0}};
          w_sat_seen_nxt = 1'b0;
        end else begin
          w_sat_seen_nxt = r_sat_seen;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt      = w_sum;
          w_sat_seen_nxt = r_sat_seen | w_sum_ovf;
          if (w_last_psum) begin
            // Packet carries the freshly saturated sum, not the old acc.
            w_out_pkt_nxt   = pack_result(r_addr, w_sum);
            w_out_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + WIDTH_CNT'(1);
          end
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (w_last_addr) begin
            // Address holds at the last neuron; only a new start clears it.
            w_frame_done_nxt = 1'b1;
          end else begin
            w_addr_nxt = r_addr + WIDTH_ADDR'(1);
            w_acc_nxt  = {WIDTH_DATA{1'b0}};
            w_cnt_nxt  = {WIDTH_CNT{1'b0}};
          end
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        w_out_valid_nxt = 1'b0;
      end
      default: begin
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator
// Directed self-checking bench for psum_accumulator with hand-computed
// expected packets. Inputs are driven and outputs sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_psum_accumulator;

  logic clk;
  logic rst_n;
  logic start;
  logic frame_done;
  logic sat_seen;

  int n_checks;
  int n_errors;
  int cyc;
  int n_done;
  int done_base;
  int t_first;
  int t_done;

  psum_accumulator_if #(.WIDTH_DATA(13), .WIDTH_PKT(32)) bus ();

  psum_accumulator #(
    .WIDTH_DATA (13),
    .WIDTH_PKT  (32),
    .WIDTH_ADDR (9),
    .DEPTH_R    (21),
    .NUM_PSUM   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .frame_done (frame_done),
    .sat_seen   (sat_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count frame_done pulses seen by the clock.
  always @(posedge clk) if (frame_done === 1'b1) n_done <= n_done + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one psum and return at the falling edge after it was accepted.
  task automatic send_psum(input logic [12:0] v);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_psum  = v;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) check_eq("psum_accept_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_psum  = 13'd0;
  endtask

  // Wait (bounded) for a packet, check it, complete handshake if out_ready.
  task automatic expect_pkt(input string tag, input logic [31:0] exp);
    int guard;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq(tag, bus.out_pkt, exp);
    if (bus.out_ready === 1'b1) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    n_done       = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_psum  = 13'd0;
    bus.out_ready = 1'b0;

    // 1. Reset, then in_valid with no start must be ignored.
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_pkt", bus.out_pkt, 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_sat_seen", 32'(sat_seen), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_psum  = 13'd55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_psum  = 13'd0;
    done_base = n_done;

    // 2. Basic sum 10+20+30 = 60 at address 0.
    bus.out_ready = 1'b1;
    pulse_start();
    check_eq("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    send_psum(13'd10);
    send_psum(13'd20);
    send_psum(13'd30);
    check_eq("pkt_latency_valid", 32'(bus.out_valid), 32'd1);
    check_eq("basic_pkt", bus.out_pkt, 32'h0000_003C);
    check_eq("basic_no_sat", 32'(sat_seen), 32'd0);
    @(negedge clk);
    check_eq("valid_drop", 32'(bus.out_valid), 32'd0);

    // 3. Saturation at address 1: 8000+100 = 8100, +100 clamps to 8191.
    send_psum(13'd8000);
    send_psum(13'd100);
    send_psum(13'd100);
    expect_pkt("sat_pkt", 32'h0000_3FFF);
    check_eq("sat_seen_set", 32'(sat_seen), 32'd1);

    // 4. Backpressure at address 2: 1+2+3 = 6, held for 5 cycles.
    bus.out_ready = 1'b0;
    send_psum(13'd1);
    send_psum(13'd2);
    send_psum(13'd3);
    check_eq("bp_pkt", bus.out_pkt, 32'h0000_4006);
    bus.in_valid = 1'b1;
    bus.in_psum  = 13'd999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check_eq("bp_pkt_hold", bus.out_pkt, 32'h0000_4006);
      check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_accept_drop", 32'(bus.out_valid), 32'd0);
    // A consumed 999 would corrupt the address-3 sum of 5+5+5 = 15.
    send_psum(13'd5);
    send_psum(13'd5);
    send_psum(13'd5);
    expect_pkt("bp_next_pkt", 32'h0000_600F);
    check_eq("sat_sticky", 32'(sat_seen), 32'd1);

    // 6. Mid-frame reset while holding address 7 in EMIT.
    for (int a = 4; a < 7; a++) begin
      send_psum(13'd2);
      send_psum(13'd2);
      send_psum(13'd2);
      expect_pkt("walk_pkt", (32'(a) << 13) | 32'd6);
    end
    bus.out_ready = 1'b0;
    send_psum(13'd4);
    send_psum(13'd4);
    send_psum(13'd4);
    check_eq("abort_pkt", bus.out_pkt, 32'h0000_E00C);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_out_pkt", bus.out_pkt, 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("abort_sat_seen", 32'(sat_seen), 32'd0);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("abort_no_done", 32'(n_done - done_base), 32'd0);
    check_eq("abort_idle_valid", 32'(bus.out_valid), 32'd0);

    // 5. Full frame of unit psums: 441 packets, addresses 0..440, data 3.
    done_base = n_done;
    pulse_start();
    t_first = 0;
    for (int a = 0; a < 441; a++) begin
      send_psum(13'd1);
      if (a == 0) t_first = cyc;
      send_psum(13'd1);
      send_psum(13'd1);
      expect_pkt("frame_pkt", (32'(a) << 13) | 32'd3);
    end
    check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
    t_done = cyc;
    // First-accept cycle through the frame_done cycle spans 441*4+1 cycles.
    check_eq("frame_cycles", 32'(t_done - t_first + 2), 32'd1765);
    @(negedge clk);
    check_eq("frame_done_once", 32'(frame_done), 32'd0);
    check_eq("post_frame_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("frame_done_count", 32'(n_done - done_base), 32'd1);
    check_eq("frame_no_sat", 32'(sat_seen), 32'd0);

    // Second frame restarts at address 0.
    pulse_start();
    check_eq("restart_in_ready", 32'(bus.in_ready), 32'd1);
    send_psum(13'd7);
    send_psum(13'd7);
    send_psum(13'd7);
    expect_pkt("restart_pkt", 32'h0000_0015);
    // start inside ACCUM must not reset the partial neuron at address 1.
    send_psum(13'd1);
    pulse_start();
    send_psum(13'd1);
    send_psum(13'd1);
    expect_pkt("start_ignored_pkt", 32'h0000_2003);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
